// File: rtl/uart_rx_param_if.sv
`default_nettype none
// ============================================================================
// Module : uart_rx_param_if
// Desc   : Receive-word output channel: data/flags plus valid/ready handshake.
// Rev    : 1.0 - initial release
// ============================================================================
interface uart_rx_param_if #(
   parameter int DATA_BITS = 8
) ();
   logic [DATA_BITS-1:0] data;
   logic                 valid;
   logic                 ready;
   logic                 parity_err;
   logic                 frame_err;
   logic                 overrun;

   modport master (output data, valid, parity_err, frame_err, overrun, input ready);
   modport slave  (input data, valid, parity_err, frame_err, overrun, output ready);
endinterface
`default_nettype wire

// File: rtl/uart_rx_param.sv
`default_nettype none
// ============================================================================
// Module : uart_rx_param
// Desc   : Parametrised UART receiver, tick-enabled oversampling, 3-sample vote.
// Rev    : 1.0 - initial release
// ============================================================================
module uart_rx_param #(
   parameter int DATA_BITS  = 8,
   parameter int OVERSAMPLE = 16,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1
) (
   input  wire logic       clk,
   input  wire logic       rst_n,
   input  wire logic       i_en,
   input  wire logic       i_tick,
   input  wire logic       i_rx,
   output logic            o_busy,
   uart_rx_param_if.master m_out
);
   localparam int              CW     = $clog2(OVERSAMPLE);
   localparam int              BW     = $clog2(DATA_BITS);
   localparam logic [CW-1:0]   c_HM1  = CW'(OVERSAMPLE/2 - 1);
   localparam logic [CW-1:0]   c_H    = CW'(OVERSAMPLE/2);
   localparam logic [CW-1:0]   c_HP1  = CW'(OVERSAMPLE/2 + 1);
   localparam logic [CW-1:0]   c_LAST = CW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0]   c_BLAST = BW'(DATA_BITS - 1);
   localparam logic            c_SLAST = (STOP_BITS == 2);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;

   state_t                r_state, w_state_nxt;
   logic [CW-1:0]         r_cnt, w_cnt_nxt;
   logic [BW-1:0]         r_bit, w_bit_nxt;
   logic                  r_stop, w_stop_nxt;
   logic [1:0]            r_smp, w_smp_nxt;
   logic [DATA_BITS-1:0]  r_shift, w_shift_nxt;
   logic                  r_par, w_par_nxt;
   logic                  r_perr, w_perr_nxt;
   logic                  r_ferr, w_ferr_nxt;
   logic                  w_done;
   logic                  r_busy;
   logic                  r_rx_meta, r_rx_s;
   logic [DATA_BITS-1:0]  r_data;
   logic                  r_valid, r_perr_out, r_ferr_out, r_overrun;

   logic                  w_decide, w_bit_end, w_vote;
   logic [CW-1:0]         w_cnt_inc;

   assign w_decide  = (r_cnt == c_HP1);
   assign w_bit_end = (r_cnt == c_LAST);
   assign w_cnt_inc = w_bit_end ? '0 : r_cnt + 1'b1;
   // Third sample is the live synchronised line at the decision tick.
   assign w_vote    = (r_smp[0] & r_smp[1]) | (r_smp[0] & r_rx_s) | (r_smp[1] & r_rx_s);

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_bit_nxt   = r_bit;
      w_stop_nxt  = r_stop;
      w_smp_nxt   = r_smp;
      w_shift_nxt = r_shift;
      w_par_nxt   = r_par;
      w_perr_nxt  = r_perr;
      w_ferr_nxt  = r_ferr;
      w_done      = 1'b0;
      if (!i_en) begin
         w_state_nxt = S_IDLE;
         w_cnt_nxt   = '0;
         w_bit_nxt   = '0;
         w_stop_nxt  = 1'b0;
      end else if (i_tick) begin
         w_cnt_nxt = w_cnt_inc;
         if (r_cnt == c_HM1) w_smp_nxt[0] = r_rx_s;
         if (r_cnt == c_H)   w_smp_nxt[1] = r_rx_s;
         case (r_state)
            S_IDLE: begin
               w_cnt_nxt = '0;
               if (!r_rx_s) begin
                  w_state_nxt = S_START;
                  w_cnt_nxt   = CW'(1);
                  w_bit_nxt   = '0;
                  w_stop_nxt  = 1'b0;
                  w_shift_nxt = '0;
                  w_par_nxt   = 1'b0;
                  w_perr_nxt  = 1'b0;
                  w_ferr_nxt  = 1'b0;
               end
            end
            S_START: begin
               if (w_decide && w_vote) begin
                  w_state_nxt = S_IDLE;
                  w_cnt_nxt   = '0;
               end else if (w_bit_end) begin
                  w_state_nxt = S_DATA;
               end
            end
            S_DATA: begin
               if (w_decide) begin
                  w_shift_nxt = {w_vote, r_shift[DATA_BITS-1:1]};
                  w_par_nxt   = r_par ^ w_vote;
               end
               if (w_bit_end) begin
                  if (r_bit == c_BLAST) begin
                     w_bit_nxt   = '0;
                     w_state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
                  end else begin
                     w_bit_nxt = r_bit + 1'b1;
                  end
               end
            end
            S_PARITY: begin
               if (w_decide)
                  w_perr_nxt = (PARITY == 1) ? ~(r_par ^ w_vote) : (r_par ^ w_vote);
               if (w_bit_end) w_state_nxt = S_STOP;
            end
            S_STOP: begin
               if (w_decide) begin
                  if (!w_vote) w_ferr_nxt = 1'b1;
                  // Finish mid-bit so a back-to-back start edge is not missed.
                  if (r_stop == c_SLAST) begin
                     w_done      = 1'b1;
                     w_state_nxt = S_IDLE;
                     w_cnt_nxt   = '0;
                     w_stop_nxt  = 1'b0;
                  end
               end
               if (w_bit_end) w_stop_nxt = r_stop + 1'b1;
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rx_meta  <= 1'b1;
         r_rx_s     <= 1'b1;
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_bit      <= '0;
         r_stop     <= 1'b0;
         r_smp      <= '0;
         r_shift    <= '0;
         r_par      <= 1'b0;
         r_perr     <= 1'b0;
         r_ferr     <= 1'b0;
         r_busy     <= 1'b0;
         r_data     <= '0;
         r_valid    <= 1'b0;
         r_perr_out <= 1'b0;
         r_ferr_out <= 1'b0;
         r_overrun  <= 1'b0;
      end else begin
         r_rx_meta <= i_rx;
         r_rx_s    <= r_rx_meta;
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_bit     <= w_bit_nxt;
         r_stop    <= w_stop_nxt;
         r_smp     <= w_smp_nxt;
         r_shift   <= w_shift_nxt;
         r_par     <= w_par_nxt;
         r_perr    <= w_perr_nxt;
         r_ferr    <= w_ferr_nxt;
         r_busy    <= (w_state_nxt != S_IDLE);
         if (w_done) begin
            r_data     <= w_shift_nxt;
            r_perr_out <= w_perr_nxt;
            r_ferr_out <= w_ferr_nxt;
            r_valid    <= 1'b1;
            r_overrun  <= r_valid & ~m_out.ready;
         end else begin
            r_overrun <= 1'b0;
            if (r_valid && m_out.ready) r_valid <= 1'b0;
         end
      end
   end

   assign o_busy           = r_busy;
   assign m_out.data       = r_data;
   assign m_out.valid      = r_valid;
   assign m_out.parity_err = r_perr_out;
   assign m_out.frame_err  = r_ferr_out;
   assign m_out.overrun    = r_overrun;
endmodule
`default_nettype wire

// File: tb/tb_uart_rx_param.sv
`default_nettype none
// ============================================================================
// Module : tb_uart_rx_param
// Desc   : Directed bench for uart_rx_param: 8N1, 7E1 and 8N2 instances.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_param;
   logic       clk;
   logic       rst_n;
   logic       en;
   logic       tick;
   logic [2:0] rx;
   logic [2:0] rdy;
   logic [2:0] busy;

   int         n_pass;
   int         n_total;
   int         got_cnt [3];
   int         ovr_cnt [3];
   logic [8:0] got_data [3];
   logic       got_perr [3];
   logic       got_ferr [3];

   uart_rx_param_if #(.DATA_BITS(8)) if0 ();
   uart_rx_param_if #(.DATA_BITS(7)) if1 ();
   uart_rx_param_if #(.DATA_BITS(8)) if2 ();

   assign if0.ready = rdy[0];
   assign if1.ready = rdy[1];
   assign if2.ready = rdy[2];

   uart_rx_param u_dut0 (
      .clk(clk), .rst_n(rst_n), .i_en(en), .i_tick(tick), .i_rx(rx[0]),
      .o_busy(busy[0]), .m_out(if0.master));

   uart_rx_param #(.DATA_BITS(7), .PARITY(2)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .i_en(en), .i_tick(tick), .i_rx(rx[1]),
      .o_busy(busy[1]), .m_out(if1.master));

   uart_rx_param #(.STOP_BITS(2)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .i_en(en), .i_tick(tick), .i_rx(rx[2]),
      .o_busy(busy[2]), .m_out(if2.master));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Consumer model: records every accepted word and every overrun pulse.
   initial begin
      for (int i = 0; i < 3; i++) begin
         got_cnt[i] = 0; ovr_cnt[i] = 0; got_data[i] = '0; got_perr[i] = 0; got_ferr[i] = 0;
      end
   end

   always @(negedge clk) begin
      if (if0.valid && if0.ready) begin
         got_cnt[0] <= got_cnt[0] + 1; got_data[0] <= {1'b0, if0.data};
         got_perr[0] <= if0.parity_err; got_ferr[0] <= if0.frame_err;
      end
      if (if1.valid && if1.ready) begin
         got_cnt[1] <= got_cnt[1] + 1; got_data[1] <= {2'b0, if1.data};
         got_perr[1] <= if1.parity_err; got_ferr[1] <= if1.frame_err;
      end
      if (if2.valid && if2.ready) begin
         got_cnt[2] <= got_cnt[2] + 1; got_data[2] <= {1'b0, if2.data};
         got_perr[2] <= if2.parity_err; got_ferr[2] <= if2.frame_err;
      end
      if (if0.overrun) ovr_cnt[0] <= ovr_cnt[0] + 1;
      if (if1.overrun) ovr_cnt[1] <= ovr_cnt[1] + 1;
      if (if2.overrun) ovr_cnt[2] <= ovr_cnt[2] + 1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive_bit(input int ch, input logic b);
      rx[ch] = b;
      repeat (16) @(posedge clk);
      #1;
   endtask

   // ch0: 8N1, ch1: 7 data + even parity + 1 stop, ch2: 8N2.
   task automatic send_frame(input int ch, input logic [8:0] d, input logic p, input logic [1:0] st);
      int db;
      db = (ch == 1) ? 7 : 8;
      drive_bit(ch, 1'b0);
      for (int i = 0; i < db; i++) drive_bit(ch, d[i]);
      if (ch == 1) drive_bit(ch, p);
      drive_bit(ch, st[0]);
      if (ch == 2) drive_bit(ch, st[1]);
      rx[ch] = 1'b1;
   endtask

   task automatic wait_word(input int ch, input int base);
      for (int i = 0; i < 60 && got_cnt[ch] == base; i++) @(posedge clk);
      #1;
   endtask

   typedef struct {
      int         ch;
      logic [8:0] data;
      logic       par;
      logic [1:0] stops;
      logic [8:0] exp_data;
      logic       exp_perr;
      logic       exp_ferr;
   } vec_t;

   vec_t vecs [11];
   int   base;
   bit   saw_busy;

   initial begin
      vecs[0]  = '{0, 9'h055, 1'b0, 2'b11, 9'h055, 1'b0, 1'b0};
      vecs[1]  = '{0, 9'h000, 1'b0, 2'b11, 9'h000, 1'b0, 1'b0};
      vecs[2]  = '{0, 9'h0FF, 1'b0, 2'b11, 9'h0FF, 1'b0, 1'b0};
      vecs[3]  = '{0, 9'h080, 1'b0, 2'b11, 9'h080, 1'b0, 1'b0};
      vecs[4]  = '{0, 9'h03C, 1'b0, 2'b10, 9'h03C, 1'b0, 1'b1};
      vecs[5]  = '{1, 9'h041, 1'b1, 2'b11, 9'h041, 1'b1, 1'b0};
      vecs[6]  = '{1, 9'h041, 1'b0, 2'b11, 9'h041, 1'b0, 1'b0};
      vecs[7]  = '{1, 9'h07F, 1'b1, 2'b11, 9'h07F, 1'b0, 1'b0};
      vecs[8]  = '{1, 9'h02A, 1'b0, 2'b11, 9'h02A, 1'b1, 1'b0};
      vecs[9]  = '{2, 9'h0FF, 1'b0, 2'b01, 9'h0FF, 1'b0, 1'b1};
      vecs[10] = '{2, 9'h05A, 1'b0, 2'b11, 9'h05A, 1'b0, 1'b0};

      n_pass = 0; n_total = 0;
      rst_n = 1'b0; en = 1'b1; tick = 1'b1; rx = '1; rdy = '1;
      idle(3);
      check("reset busy",    {29'd0, busy}, 32'd0);
      check("reset valid",   {29'd0, if0.valid, if1.valid, if2.valid}, 32'd0);
      check("reset outputs", {if0.data, if0.parity_err, if0.frame_err, if0.overrun}, 32'd0);
      rst_n = 1'b1;
      idle(5);

      for (int v = 0; v < 11; v++) begin
         base = got_cnt[vecs[v].ch];
         send_frame(vecs[v].ch, vecs[v].data, vecs[v].par, vecs[v].stops);
         wait_word(vecs[v].ch, base);
         check($sformatf("vec%0d count", v), got_cnt[vecs[v].ch], base + 1);
         check($sformatf("vec%0d data", v), {23'd0, got_data[vecs[v].ch]}, {23'd0, vecs[v].exp_data});
         check($sformatf("vec%0d parity_err", v), {31'd0, got_perr[vecs[v].ch]}, {31'd0, vecs[v].exp_perr});
         check($sformatf("vec%0d frame_err", v), {31'd0, got_ferr[vecs[v].ch]}, {31'd0, vecs[v].exp_ferr});
         idle(20);
         check($sformatf("vec%0d busy idle", v), {31'd0, busy[vecs[v].ch]}, 32'd0);
      end

      // Short low pulse on ch0: start rejected, then a real frame.
      base = got_cnt[0];
      saw_busy = 0;
      rx[0] = 1'b0;
      idle(4);
      rx[0] = 1'b1;
      for (int i = 0; i < 25; i++) begin
         @(negedge clk);
         if (busy[0]) saw_busy = 1;
      end
      check("glitch busy seen", {31'd0, saw_busy}, 32'd1);
      check("glitch busy cleared", {31'd0, busy[0]}, 32'd0);
      check("glitch no word", got_cnt[0], base);
      idle(1);
      send_frame(0, 9'h0A3, 1'b0, 2'b11);
      wait_word(0, base);
      check("after glitch count", got_cnt[0], base + 1);
      check("after glitch data", {23'd0, got_data[0]}, 32'h0A3);
      idle(20);

      // Enable dropped mid-start: busy falls next clk, no word.
      base = got_cnt[0];
      rx[0] = 1'b0;
      idle(8);
      check("en busy before", {31'd0, busy[0]}, 32'd1);
      en = 1'b0;
      idle(1);
      check("en busy after", {31'd0, busy[0]}, 32'd0);
      rx[0] = 1'b1;
      en = 1'b1;
      idle(30);
      check("en no word", got_cnt[0], base);

      // Back-to-back frames with consumer stalled.
      base = got_cnt[0];
      rdy[0] = 1'b0;
      send_frame(0, 9'h012, 1'b0, 2'b11);
      send_frame(0, 9'h034, 1'b0, 2'b11);
      idle(20);
      check("overrun pulses", ovr_cnt[0], 1);
      check("overrun data", {24'd0, if0.data}, 32'h34);
      check("overrun valid held", {31'd0, if0.valid}, 32'd1);
      check("overrun no accept", got_cnt[0], base);
      rdy[0] = 1'b1;
      idle(3);
      check("overrun accept count", got_cnt[0], base + 1);
      check("overrun accept data", {23'd0, got_data[0]}, 32'h034);
      check("overrun valid cleared", {31'd0, if0.valid}, 32'd0);

      // Reset asserted partway through the data bits.
      drive_bit(0, 1'b0);
      drive_bit(0, 1'b1);
      drive_bit(0, 1'b0);
      check("pre-reset busy", {31'd0, busy[0]}, 32'd1);
      rst_n = 1'b0;
      rx[0] = 1'b1;
      #2;
      check("mid reset busy", {31'd0, busy[0]}, 32'd0);
      check("mid reset outputs",
            {if0.data, if0.valid, if0.parity_err, if0.frame_err, if0.overrun}, 32'd0);
      idle(3);
      rst_n = 1'b1;
      idle(5);
      base = got_cnt[0];
      send_frame(0, 9'h00F, 1'b0, 2'b11);
      wait_word(0, base);
      idle(20);
      check("post reset count", got_cnt[0], base + 1);
      check("post reset data", {23'd0, got_data[0]}, 32'h00F);
      check("post reset flags", {30'd0, got_perr[0], got_ferr[0]}, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised UART receiver, the successor to the fixed 8N1 receiver. Configurable data width, oversampling ratio, parity and stop bits. Oversample timing comes from an external tick enable, so the block runs on the system clock. Uses 3-sample majority voting, flags framing and parity errors, and presents each received word on a valid/ready output register with overrun detection. Sits between the pad-side RX line and a byte consumer (FIFO or register file).

Parameters:
DATA_BITS, 8, data bits per frame; legal 5..9; sent LSB first.
OVERSAMPLE, 16, ticks per bit period; even, >=8.
PARITY, 0, 0 = none, 1 = odd, 2 = even.
STOP_BITS, 1, 1 or 2.

Ports:
clk  input  1  system clock.
rst  input  1  asynchronous active-low reset.
en  input  1  receiver enable; low forces IDLE synchronously.
tick  input  1  oversample strobe, OVERSAMPLE pulses per bit; one clk wide.
rx  input  1  UART line; asynchronous; idles high.
busy  output  1  high while a frame is in progress (state != IDLE).
data_out  output  DATA_BITS  received word.
valid  output  1  data_out and flags hold an unconsumed word.
ready  input  1  consumer accepts the word when valid & ready.
parity_err  output  1  parity mismatch for the word in data_out; 0 when PARITY=0.
frame_err  output  1  a stop bit was sampled low for the word in data_out.
overrun  output  1  one-clk pulse: a new word overwrote an unconsumed one.

Behaviour:
- Reset (rst low, async):
  - state IDLE; all counters 0.
  - Outputs 0: busy, data_out, valid, parity_err, frame_err, overrun.
  - 2-flop rx synchroniser resets to 1. All logic uses the synchronised rx_s; latency 2 clk.
- Counters:
  - cnt advances only on tick. H = OVERSAMPLE/2.
  - Samples are taken at cnt = H-1, H, H+1. The bit value is the majority of the 3, decided at cnt == H+1.
  - At cnt == OVERSAMPLE-1, cnt wraps to 0 and the state advances.
- IDLE:
  - On a tick with rx_s == 0 and en high: go to START, cnt = 1, clear the shift register, parity accumulator and error accumulators.
- START:
  - Decision 1 (glitch): return to IDLE immediately. No valid, no flags.
  - Decision 0: continue to DATA at bit end.
- DATA:
  - DATA_BITS bits. Each decision shifts into the MSB of the shift register, so the word is LSB-first aligned after the last bit.
  - Bit index counts 0..DATA_BITS-1, then go to PARITY if PARITY != 0, else STOP.
- PARITY:
  - Decision is XORed with the data XOR.
  - Error if odd mode and result 0, or even mode and result 1.
- STOP (STOP_BITS times):
  - Decision 0 sets the frame-error accumulator.
  - At the decision point of the last stop bit (cnt == H+1, not bit end), complete the frame and return to IDLE. This allows resynchronisation to a back-to-back start bit.
  - Intermediate stop bits advance at bit end.
- Completion (one clk):
  - Load data_out, parity_err, frame_err; set valid.
  - If valid was already 1 and not (valid & ready) that cycle: pulse overrun, overwrite data.
  - If valid & ready in the same cycle: no overrun; valid stays 1.
  - A frame with frame_err is still delivered.
- Handshake:
  - valid clears on valid & ready when no completion occurs that cycle.
  - data_out and the flags are held stable while valid is 1 and no completion occurs.
- en low:
  - Next clk: state IDLE, busy 0, counters cleared.
  - valid, data_out and flags are unaffected; the output handshake still works.
- tick low: the FSM holds state; handshake logic runs every clk.
- busy = (state != IDLE), registered with the state.

Test Plan:
- Defaults, tick every clk, frame 0x55 (8N1), ready held high -> valid pulses 1 clk with data_out=0x55, parity_err=0, frame_err=0, busy low after stop decision.
- PARITY=2, DATA_BITS=7, send 0x41 with parity bit 1 -> data_out=0x41, parity_err=1; resend with parity bit 0 -> parity_err=0.
- rx low for 4 ticks then high (OVERSAMPLE=16) -> busy rises then falls at cnt==H+1; no valid; next real frame 0xA3 received correctly.
- STOP_BITS=2, second stop bit driven 0, frame 0xFF -> valid with data_out=0xFF, frame_err=1.
- ready low, two back-to-back frames 0x12 then 0x34 -> overrun pulses once at second completion; data_out=0x34; valid stays 1 until ready.
- rst asserted mid-DATA, released, frame 0x0F sent -> all outputs 0 during reset; only 0x0F delivered, no error flags.
